clock_gate_ctrl: RTL and testbench

// - Per-domain clock-gating sequencer; drives en_i of one prim_clock_gating cell per domain.
// - Gates a domain after a programmable idle window.
// - Ungates on demand; round-robin wake scheduler allows at most one domain in WAKE at a time (limits inrush).
// - Sits in the always-on clock region beside the core/peripheral clock gates.

---
 rtl/clock_gate_ctrl.sv | 173 +++++++++++++++++
 tb/tb_clock_gate_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_gate_ctrl.sv
// Per-domain clock-gating sequencer (ON -> DRAIN -> OFF -> WAKE -> ON) with a round-robin wake
// scheduler. Define CLKGATE_STATS_EN to build the per-domain gated-cycle counters.
module clock_gate_ctrl #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_LAT    = 2,
  parameter int unsigned STAT_W      = 16,
  localparam int unsigned SelW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_DOMAINS-1:0] busy_i,
  input  logic [NUM_DOMAINS-1:0] wake_req_i,
  input  logic                   sleep_allow_i,
  input  logic                   force_on_i,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic [NUM_DOMAINS-1:0] gated_o,
  output logic [NUM_DOMAINS-1:0] ready_o,
  input  logic [SelW-1:0]        stat_sel_i,
  input  logic                   stat_clr_i,
  output logic [STAT_W-1:0]      stat_cnt_o
);

  localparam int unsigned IdleW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int unsigned WakeW = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;

  typedef enum logic [1:0] {StOn, StDrain, StOff, StWake} state_e;

  state_e                 state_q [NUM_DOMAINS];
  state_e                 state_d [NUM_DOMAINS];
  logic [IdleW-1:0]       idle_q  [NUM_DOMAINS];
  logic [IdleW-1:0]       idle_d  [NUM_DOMAINS];
  logic [WakeW-1:0]       wcnt_q  [NUM_DOMAINS];
  logic [WakeW-1:0]       wcnt_d  [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] pend_q, pend_d;
  logic [SelW-1:0]        ptr_q, ptr_d;
  logic [NUM_DOMAINS-1:0] clk_en_q, clk_en_d, gated_q, gated_d, ready_q, ready_d;
  logic [NUM_DOMAINS-1:0] grant;
  logic                   slot_free, found;
  int                     idx;

  // The wake slot counts as free during the last WAKE cycle so back-to-back grants never overlap.
  always_comb begin
    slot_free = !force_on_i;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (state_q[i] == StWake && wcnt_q[i] != WakeW'(WAKE_LAT - 1)) slot_free = 1'b0;
    end
    grant = '0;
    found = 1'b0;
    ptr_d = ptr_q;
    idx   = 0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      idx = (int'(ptr_q) + k) % int'(NUM_DOMAINS);
      if (slot_free && !found && pend_q[idx] && state_q[idx] == StOff) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = SelW'((idx + 1) % int'(NUM_DOMAINS));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      state_d[i] = state_q[i];
      idle_d[i]  = idle_q[i];
      wcnt_d[i]  = wcnt_q[i];
      pend_d[i]  = pend_q[i];
      unique case (state_q[i])
        StOn: begin
          if (busy_i[i] || wake_req_i[i] || !sleep_allow_i || force_on_i) begin
            idle_d[i] = '0;
          end else if (idle_q[i] == IdleW'(IDLE_CYCLES - 1)) begin
            state_d[i] = StDrain;
          end else begin
            idle_d[i] = idle_q[i] + 1'b1;
          end
        end
        StDrain: begin
          if (busy_i[i] || wake_req_i[i] || force_on_i) begin
            state_d[i] = StOn;
            idle_d[i]  = '0;
          end else begin
            state_d[i] = StOff;
          end
        end
        StOff: begin
          if (force_on_i || grant[i]) begin
            state_d[i] = StWake;
            wcnt_d[i]  = '0;
            pend_d[i]  = 1'b0;
          end else if (busy_i[i] || wake_req_i[i]) begin
            pend_d[i] = 1'b1;
          end
        end
        StWake: begin
          if (wcnt_q[i] == WakeW'(WAKE_LAT - 1)) begin
            state_d[i] = StOn;
            idle_d[i]  = '0;
          end else begin
            wcnt_d[i] = wcnt_q[i] + 1'b1;
          end
        end
      endcase
      clk_en_d[i] = (state_d[i] != StOff);
      gated_d[i]  = (state_d[i] == StOff);
      ready_d[i]  = (state_d[i] == StOn);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        state_q[i] <= StOn;
        idle_q[i]  <= '0;
        wcnt_q[i]  <= '0;
      end
      pend_q   <= '0;
      ptr_q    <= '0;
      clk_en_q <= '1;
      gated_q  <= '0;
      ready_q  <= '1;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      wcnt_q   <= wcnt_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      clk_en_q <= clk_en_d;
      gated_q  <= gated_d;
      ready_q  <= ready_d;
    end
  end

  assign clk_en_o = clk_en_q;
  assign gated_o  = gated_q;
  assign ready_o  = ready_q;

`ifdef CLKGATE_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_DOMAINS];
  logic [STAT_W-1:0] stat_d [NUM_DOMAINS];
  logic [STAT_W-1:0] stat_out_q, stat_out_d;

  always_comb begin
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr_i) begin
        stat_d[i] = '0;
      end else if (state_q[i] == StOff && stat_q[i] != '1) begin
        stat_d[i] = stat_q[i] + 1'b1;
      end
    end
    stat_out_d = '0;
    if (!stat_clr_i && 32'(stat_sel_i) < NUM_DOMAINS) stat_out_d = stat_d[stat_sel_i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_DOMAINS; i++) stat_q[i] <= '0;
      stat_out_q <= '0;
    end else begin
      stat_q     <= stat_d;
      stat_out_q <= stat_out_d;
    end
  end

  assign stat_cnt_o = stat_out_q;
`else
  logic unused_stat;
  assign unused_stat = ^{stat_sel_i, stat_clr_i};
  assign stat_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: a cycle-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed cycle counts.
module tb_clock_gate_ctrl;
  localparam int N    = 4;
  localparam int IDLE = 16;
  localparam int WL   = 2;
  localparam int SW   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  busy, wake_req, clk_en, gated, ready;
  logic          sleep_allow, force_on, stat_clr;
  logic [1:0]    stat_sel;
  logic [SW-1:0] stat_cnt;

  always #5 clk = ~clk;

  clock_gate_ctrl #(
    .NUM_DOMAINS(N), .IDLE_CYCLES(IDLE), .WAKE_LAT(WL), .STAT_W(SW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .busy_i(busy), .wake_req_i(wake_req),
    .sleep_allow_i(sleep_allow), .force_on_i(force_on), .clk_en_o(clk_en), .gated_o(gated),
    .ready_o(ready), .stat_sel_i(stat_sel), .stat_clr_i(stat_clr), .stat_cnt_o(stat_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each domain is described by "gated", "draining", remaining wake cycles, and the
  // length of its current idle run; pending wakes are served round-robin.
  bit m_off [N], m_drain [N], m_pend [N];
  int m_idle [N], m_wleft [N], m_stat [N];
  int m_ptr, m_stat_out;

  always @(posedge clk) begin : model_p
    int g, idx;
    bit slot, b, w;
    bit old_off [N];
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_off[i] = 0; m_drain[i] = 0; m_pend[i] = 0; m_idle[i] = 0; m_wleft[i] = 0;
        m_stat[i] = 0;
      end
      m_ptr = 0;
      m_stat_out = 0;
    end else begin
      slot = !force_on;
      for (int i = 0; i < N; i++) if (m_wleft[i] > 1) slot = 0;
      g = -1;
      if (slot) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && m_off[idx] && m_pend[idx]) g = idx;
        end
      end
      for (int i = 0; i < N; i++) old_off[i] = m_off[i];
      for (int i = 0; i < N; i++) begin
        b = busy[i];
        w = wake_req[i];
        if (m_wleft[i] > 0) begin
          m_wleft[i]--;
          if (m_wleft[i] == 0) m_idle[i] = 0;
        end else if (m_off[i]) begin
          if (force_on || i == g) begin
            m_off[i] = 0; m_pend[i] = 0; m_wleft[i] = WL; m_idle[i] = 0;
          end else if (b || w) begin
            m_pend[i] = 1;
          end
        end else if (m_drain[i]) begin
          m_drain[i] = 0;
          if (b || w || force_on) m_idle[i] = 0;
          else m_off[i] = 1;
        end else begin
          if (!b && !w && sleep_allow && !force_on) begin
            m_idle[i]++;
            if (m_idle[i] >= IDLE) m_drain[i] = 1;
          end else begin
            m_idle[i] = 0;
          end
        end
      end
      if (g >= 0) m_ptr = (g + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (stat_clr) m_stat[i] = 0;
        else if (old_off[i] && m_stat[i] < (1 << SW) - 1) m_stat[i]++;
      end
      m_stat_out = (!stat_clr && int'(stat_sel) < N) ? m_stat[stat_sel] : 0;
    end
  end

  always @(negedge clk) begin : compare_p
    logic [N-1:0] e_en, e_gt, e_rd;
    int e_st;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        e_en[i] = !m_off[i];
        e_gt[i] = m_off[i];
        e_rd[i] = !m_off[i] && !m_drain[i] && m_wleft[i] == 0;
      end
`ifdef CLKGATE_STATS_EN
      e_st = m_stat_out;
`else
      e_st = 0;
`endif
      cmp("model_clk_en", clk_en, e_en);
      cmp("model_gated", gated, e_gt);
      cmp("model_ready", ready, e_rd);
      cmp("model_stat", stat_cnt, e_st);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int k, en_k, rdy_k, two_wake, nw;
    int r [N];
    bit hold;
    rst_n = 0; busy = '1; wake_req = '0; sleep_allow = 1; force_on = 0;
    stat_sel = 0; stat_clr = 0;
    tick(3);
    cmp("reset_clk_en", clk_en, 4'hF);
    cmp("reset_gated", gated, 4'h0);
    cmp("reset_ready", ready, 4'hF);
    rst_n = 1;
    chk_en = 1;
    tick(2);

    // Domain 0 goes idle; the enable must fall IDLE+1 cycles after the last busy cycle.
    busy = 4'b1110;
    k = 0;
    do begin tick(1); k++; end while (clk_en[0] && k < 40);
    cmp("idle_drop_cycles", k, 17);
    cmp("gated_same_cycle", gated[0], 1);

    busy = '0;
    tick(20);
    cmp("all_gated", gated, 4'hF);

    // Single wake of domain 2.
    wake_req = 4'b0100;
    tick(1);
    wake_req = '0;
    k = 1; en_k = 0; rdy_k = 0;
    while (k < 12 && rdy_k == 0) begin
      if (en_k == 0 && clk_en[2]) en_k = k;
      if (rdy_k == 0 && ready[2]) rdy_k = k;
      if (rdy_k == 0) begin tick(1); k++; end
    end
    cmp("wake_clk_en_latency", en_k, 2);
    cmp("wake_ready_latency", rdy_k, 4);

    // Wake domain 3 so the round-robin pointer wraps back to 0.
    wake_req = 4'b1000;
    tick(1);
    wake_req = '0;
    tick(25);
    cmp("all_gated_again", gated, 4'hF);
    cmp("model_ptr_zero", m_ptr, 0);

    // Three simultaneous requests: expect WAKE order 0,1,3 with ready 2 cycles apart.
    wake_req = 4'b1011;
    tick(1);
    wake_req = '0;
    for (int i = 0; i < N; i++) r[i] = 0;
    two_wake = 0;
    for (int kk = 1; kk <= 12; kk++) begin
      nw = 0;
      for (int i = 0; i < N; i++) begin
        if (clk_en[i] && !ready[i] && !gated[i]) nw++;
        if (r[i] == 0 && ready[i]) r[i] = kk;
      end
      if (nw > 1) two_wake++;
      tick(1);
    end
    cmp("rr_ready_d0", r[0], 4);
    cmp("rr_ready_d1", r[1], 6);
    cmp("rr_ready_d3", r[3], 8);
    cmp("rr_never_two_wake", two_wake, 0);
    cmp("rr_d2_stays_gated", gated[2], 1);
    tick(25);

    // busy on an OFF domain wakes it with the same latency as wake_req.
    busy = 4'b0010;
    k = 0;
    do begin tick(1); k++; end while (!ready[1] && k < 20);
    cmp("busy_wake_latency", k, 4);
    busy = '0;
    k = 0;
    do begin tick(1); k++; end while (ready[1] && k < 40);
    cmp("drain_entry_cycles", k, 16);
    cmp("drain_clk_en", clk_en[1], 1);
    busy = 4'b0010;
    tick(1);
    busy = '0;
    cmp("drain_bounce_ready", ready[1], 1);
    cmp("drain_bounce_clk_en", clk_en[1], 1);
    k = 0;
    do begin tick(1); k++; end while (clk_en[1] && k < 40);
    cmp("regate_after_bounce", k, 17);

    // Force-on with every domain OFF.
    tick(2);
    force_on = 1;
    tick(1);
    cmp("force_all_on", clk_en, 4'hF);
    hold = 1;
    repeat (100) begin
      tick(1);
      if (clk_en != 4'hF) hold = 0;
    end
    cmp("force_holds_100", hold, 1);
    cmp("force_ready", ready, 4'hF);

    force_on = 0;
    sleep_allow = 0;
    tick(30);
    cmp("sleep_block_no_gate", clk_en, 4'hF);
    sleep_allow = 1;
    tick(20);
    cmp("sleep_allow_gates", gated, 4'hF);

    stat_clr = 1;
    tick(1);
    stat_clr = 0;
    cmp("stat_after_clr", stat_cnt, 0);
    tick(50);
`ifdef CLKGATE_STATS_EN
    cmp("stat_50_off", stat_cnt, 50);
`else
    cmp("stat_tied_zero", stat_cnt, 0);
`endif
    stat_clr = 1;
    tick(1);
    stat_clr = 0;
    cmp("stat_clr_pulse", stat_cnt, 0);

    // Reset while domain 0 is in WAKE.
    wake_req = 4'b0001;
    tick(1);
    wake_req = '0;
    tick(2);
    rst_n = 0;
    tick(1);
    cmp("midwake_reset_clk_en", clk_en, 4'hF);
    cmp("midwake_reset_ready", ready, 4'hF);
    cmp("midwake_reset_gated", gated, 4'h0);
    rst_n = 1;
    tick(2);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
